deserializer_aligner: RTL

//   Receive side of the serial test link. Consumes the 1-bit MSB-first stream

---
 rtl/link_pkg.sv | 13 +
 rtl/deserializer_aligner.sv | 118 +++++++++++
 2 files changed

// File: rtl/link_pkg.sv
// Shared definitions for the serial test link (serializer and deserializer sides).
package link_pkg;

  localparam int                    LINK_WIDTH   = 8;
  localparam logic [LINK_WIDTH-1:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } link_state_e;

endpackage

// File: rtl/deserializer_aligner.sv
// Serial-to-parallel receiver: hunts for the sync word, confirms word alignment,
// then delivers aligned payload words with a single-cycle valid strobe.
module deserializer_aligner
  import link_pkg::*;
#(
  parameter int               WIDTH      = LINK_WIDTH,
  parameter logic [WIDTH-1:0] SYNC_WORD  = SYNC_DEFAULT,
  parameter int               LOCK_COUNT = 2,
  parameter int               WCNT_W     = 16
) (
  input  logic              t_clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              serial_in,
  output logic [WIDTH-1:0]  data_out,
  output logic              data_valid,
  output logic              locked,
  output logic [WCNT_W-1:0] word_cnt
);

  localparam int CNT_W  = $clog2(WIDTH);
  localparam int SYNC_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  FIRST_BIT  = CNT_W'(1);
  localparam logic [SYNC_W-1:0] SYNC_ONE   = SYNC_W'(1);
  localparam logic [SYNC_W-1:0] SYNC_FINAL = SYNC_W'(LOCK_COUNT - 1);

  logic [WIDTH-1:0]  shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [SYNC_W-1:0] sync_cnt;
  logic              preamble;
  link_state_e       state;

  logic             boundary;
  logic             sync_match;
  logic [CNT_W-1:0] bit_cnt_nxt;

  assign boundary    = (bit_cnt == '0);
  assign sync_match  = (shreg == SYNC_WORD);
  assign bit_cnt_nxt = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;

  // NOTE: every register here uses non-blocking assignment so each branch
  // reads the pre-edge shreg/bit_cnt, which is what the boundary decision relies on.
  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      sync_cnt   <= '0;
      state      <= HUNT;
      data_out   <= '0;
      data_valid <= 1'b0;
      locked     <= 1'b0;
      word_cnt   <= '0;
      preamble   <= 1'b1;
    end else if (!en) begin
      // Disable is a synchronous copy of reset: any partial word is discarded.
      shreg      <= '0;
      bit_cnt    <= '0;
      sync_cnt   <= '0;
      state      <= HUNT;
      data_out   <= '0;
      data_valid <= 1'b0;
      locked     <= 1'b0;
      word_cnt   <= '0;
      preamble   <= 1'b1;
    end else begin
      shreg      <= {shreg[WIDTH-2:0], serial_in};
      data_valid <= 1'b0;

      unique case (state)
        HUNT: begin
          bit_cnt <= '0;
          if (sync_match) begin
            state    <= CONFIRM;
            bit_cnt  <= FIRST_BIT;
            sync_cnt <= SYNC_ONE;
          end
        end

        CONFIRM: begin
          bit_cnt <= bit_cnt_nxt;
          if (boundary) begin
            if (sync_match) begin
              sync_cnt <= sync_cnt + 1'b1;
              if (sync_cnt == SYNC_FINAL) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                preamble <= 1'b1;
              end
            end else begin
              state    <= HUNT;
              sync_cnt <= '0;
              bit_cnt  <= '0;
            end
          end
        end

        LOCKED: begin
          bit_cnt <= bit_cnt_nxt;
          // Repeated sync words right after lock are preamble, not payload.
          if (boundary && !(preamble && sync_match)) begin
            preamble   <= 1'b0;
            data_out   <= shreg;
            data_valid <= 1'b1;
            if (word_cnt != '1) word_cnt <= word_cnt + 1'b1;
          end
        end

        default: begin
          state   <= HUNT;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule
